// File: rtl/sample_scheduler.sv
// sample_scheduler
//   Shares the single-voice SampleBank between sound-cue requesters. One-cycle
//   cue pulses are latched into pending flags. The highest pending index wins
//   and is issued as a one-cycle trigger. A minimum play window then follows,
//   and only a strictly higher-priority cue can cut that window short.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_req          one-cycle cue request pulses, bit index = sample index = priority
//   i_mute         suppresses new triggers and discards pending/new requests
//   o_select       sample index to SampleBank, changes only with o_trigger
//   o_trigger      one-cycle start pulse to SampleBank
//   o_busy         high while the scheduler is not idle
//   o_drop_count   saturating count of selections that discarded lower cues
module sample_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int SELECT_BITS = 2,
   parameter int HOLD_CYCLES = 2000000
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic                   i_mute,
   output logic [SELECT_BITS-1:0] o_select,
   output logic                   o_trigger,
   output logic                   o_busy,
   output logic [7:0]             o_drop_count
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_TRIG, S_PLAY} state_t;

   state_t                 r_state;
   logic [NUM_REQ-1:0]     r_pend;
   logic [IDX_W-1:0]       r_cur_prio;
   logic [CNT_W-1:0]       r_cnt;
   logic [SELECT_BITS-1:0] r_select;
   logic                   r_trigger;
   logic                   r_busy;
   logic [7:0]             r_drop;

   logic [IDX_W-1:0]       w_winner;
   logic [NUM_REQ-1:0]     w_low;    // pend positions below the winner
   logic [NUM_REQ-1:0]     w_clear;  // winner plus everything below it
   logic                   w_any;
   logic                   w_sel;    // this edge issues a new trigger
   logic                   w_drop;   // this selection discards a lower cue

   always_comb begin
      w_winner = '0;
      w_low    = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (r_pend[i]) w_winner = IDX_W'(i);
      for (int i = 0; i < NUM_REQ; i++)
         if (IDX_W'(i) < w_winner) w_low[i] = 1'b1;
      w_clear           = w_low;
      w_clear[w_winner] = 1'b1;
      w_any  = |r_pend;
      // Preemption needs a strictly higher index than the cue now playing.
      w_sel  = !i_mute && w_any &&
               ((r_state == S_IDLE) ||
                ((r_state == S_PLAY) && (w_winner > r_cur_prio)));
      w_drop = |(r_pend & w_low);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_pend     <= '0;
         r_cur_prio <= '0;
         r_cnt      <= '0;
         r_select   <= '0;
         r_trigger  <= 1'b0;
         r_busy     <= 1'b0;
         r_drop     <= '0;
      end else begin
         // A fresh request in the selection cycle survives the clear.
         if (i_mute)     r_pend <= '0;
         else if (w_sel) r_pend <= (r_pend & ~w_clear) | i_req;
         else            r_pend <= r_pend | i_req;

         if (w_sel && w_drop && (r_drop != 8'hFF))
            r_drop <= r_drop + 8'd1;

         r_trigger <= 1'b0;
         if (w_sel) begin
            r_select   <= SELECT_BITS'(w_winner);
            r_cur_prio <= w_winner;
            r_trigger  <= 1'b1;
            r_state    <= S_TRIG;
            r_busy     <= 1'b1;
         end else begin
            case (r_state)
               S_TRIG: begin
                  r_cnt   <= HOLD_LOAD;
                  r_state <= S_PLAY;
                  r_busy  <= 1'b1;
               end
               S_PLAY: begin
                  // Mute does not abort the window; it only blocks w_sel.
                  if (r_cnt == '0) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_select     = r_select;
   assign o_trigger    = r_trigger;
   assign o_busy       = r_busy;
   assign o_drop_count = r_drop;

endmodule

// File: tb/tb_sample_scheduler.sv
// tb_sample_scheduler
//   Directed stimulus for sample_scheduler (NUM_REQ=4, HOLD_CYCLES=8).
//   Each expected trigger (cycle, select) is queued when its request is issued;
//   a negedge monitor pops and compares on every observed trigger.
module tb_sample_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       mute;
   logic [1:0] sel;
   logic       trig;
   logic       busy;
   logic [7:0] drop;

   sample_scheduler #(.NUM_REQ(4), .SELECT_BITS(2), .HOLD_CYCLES(8)) dut (
      .i_clk(clk), .i_reset(rst), .i_req(req), .i_mute(mute),
      .o_select(sel), .o_trigger(trig), .o_busy(busy), .o_drop_count(drop)
   );

   typedef struct {
      int cyc;
      int sel;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc     = 0;
   int   n_check = 0;
   int   n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Trigger monitor: every trigger must match the head of the queue.
   always @(negedge clk) begin
      if (trig) begin
         n_check++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_trigger: cycle %0d select %0d, expected no trigger", cyc, sel);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.cyc != cyc || mon_e.sel != int'(sel)) begin
               n_fail++;
               $display("FAIL trigger: got cycle %0d select %0d, expected cycle %0d select %0d",
                        cyc, sel, mon_e.cyc, mon_e.sel);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic advance_to(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic pulse(input logic [3:0] r);
      req = r;
      tick(1);
      req = 4'b0000;
   endtask

   task automatic expect_trig(input int c, input int s);
      exp_t e;
      e.cyc = c;
      e.sel = s;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_check++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      int t;
      int tt;
      rst  = 1'b1;
      req  = 4'b0000;
      mute = 1'b0;
      tick(3);
      check("reset_select", sel, 0);
      check("reset_trigger", trig, 0);
      check("reset_busy", busy, 0);
      check("reset_drop", drop, 0);
      rst = 1'b0;

      // Single cue in cycle 10.
      advance_to(10);
      t = cyc;
      expect_trig(t + 2, 1);
      pulse(4'b0010);
      check("single_busy_pre", busy, 0);
      for (int k = 2; k <= 12; k++) begin
         tick(1);
         check($sformatf("single_busy_t+%0d", k), busy, (k <= 10) ? 1 : 0);
      end
      check("single_drop", drop, 0);
      check("single_pending", exp_q.size(), 0);

      // Simultaneous 2 and 0: 2 wins, 0 is discarded.
      tick(2);
      t = cyc;
      expect_trig(t + 2, 2);
      pulse(4'b0101);
      tick(25);
      check("simul_drop", drop, 1);
      check("simul_pending", exp_q.size(), 0);

      // Preemption of index 1 by index 3.
      t  = cyc;
      tt = t + 2;
      expect_trig(tt, 1);
      pulse(4'b0010);
      advance_to(tt + 3);
      expect_trig(tt + 5, 3);
      pulse(4'b1000);
      advance_to(tt + 13);
      check("preempt_busy_end", busy, 1);
      tick(1);
      check("preempt_busy_idle", busy, 0);
      check("preempt_drop", drop, 1);
      tick(3);
      check("preempt_pending", exp_q.size(), 0);

      // Lower cue during PLAY waits for IDLE.
      t  = cyc;
      tt = t + 2;
      expect_trig(tt, 2);
      pulse(4'b0100);
      advance_to(tt + 2);
      expect_trig(tt + 10, 0);
      pulse(4'b0001);
      advance_to(tt + 9);
      check("defer_idle_busy", busy, 0);
      advance_to(tt + 20);
      check("defer_drop", drop, 1);
      check("defer_pending", exp_q.size(), 0);

      // Mute: requests discarded, nothing triggers afterwards.
      mute = 1'b1;
      tick(1);
      pulse(4'b1000);
      tick(5);
      mute = 1'b0;
      tick(1);
      pulse(4'b0010);
      mute = 1'b1;
      tick(5);
      mute = 1'b0;
      tick(10);
      check("mute_busy", busy, 0);
      check("mute_drop", drop, 1);
      check("mute_pending", exp_q.size(), 0);

      // Reset in the middle of PLAY.
      t = cyc;
      expect_trig(t + 2, 2);
      pulse(4'b0100);
      advance_to(t + 5);
      check("play_busy", busy, 1);
      rst = 1'b1;
      tick(1);
      check("midreset_select", sel, 0);
      check("midreset_trigger", trig, 0);
      check("midreset_busy", busy, 0);
      check("midreset_drop", drop, 0);
      rst = 1'b0;
      tick(2);
      check("midreset_pending", exp_q.size(), 0);

      // Saturation of the drop counter.
      for (int i = 0; i < 300; i++) begin
         t = cyc;
         expect_trig(t + 2, 1);
         pulse(4'b0011);
         tick(11);
         if (i == 99) check("sat_drop_100", drop, 100);
         if (i == 254) check("sat_drop_255", drop, 255);
      end
      check("sat_drop_final", drop, 255);
      check("sat_pending", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
      $finish;
   end

endmodule
